// File: rtl/stack_pointer_if.sv
// Stack pointer request/status bundle shared between the control unit
// (master) and the stack pointer register (slave).
interface stack_pointer_if #(
  parameter int unsigned WIDTH = 16
);
  logic             push;
  logic             pop;
  logic [WIDTH-1:0] out;
  logic             empty;
  logic             full;
  logic             overflow;
  logic             underflow;

  modport master (
    output push, pop,
    input  out, empty, full, overflow, underflow
  );

  modport slave (
    input  push, pop,
    output out, empty, full, overflow, underflow
  );
endinterface

// File: rtl/stack_pointer.sv
// fdt16 stack pointer: downward-growing stack bounded by TOP (empty) and
// LIMIT (full). Push decrements, pop increments; a refused request produces
// a one-cycle overflow/underflow pulse.
module stack_pointer #(
  parameter int unsigned      WIDTH = 16,
  parameter logic [WIDTH-1:0] TOP   = 16'hFFFF,
  parameter logic [WIDTH-1:0] LIMIT = 16'hF000
) (
  input  logic           clk,
  input  logic           reset,
  stack_pointer_if.slave sp
);

  localparam logic [WIDTH-1:0] STEP = {{(WIDTH-1){1'b0}}, 1'b1};

  logic [WIDTH-1:0] ptr_r;
  logic             overflow_r;
  logic             underflow_r;

  logic [WIDTH-1:0] ptr_nxt_s;
  logic             overflow_nxt_s;
  logic             underflow_nxt_s;

  // Next pointer and error pulses; the bounds checks make wrap-around impossible.
  always_comb begin
    ptr_nxt_s       = ptr_r;
    overflow_nxt_s  = 1'b0;
    underflow_nxt_s = 1'b0;
    if (sp.push && !sp.pop) begin
      if (ptr_r == LIMIT) begin
        overflow_nxt_s = 1'b1;
      end else begin
        ptr_nxt_s = ptr_r - STEP;
      end
    end else if (sp.pop && !sp.push) begin
      if (ptr_r == TOP) begin
        underflow_nxt_s = 1'b1;
      end else begin
        ptr_nxt_s = ptr_r + STEP;
      end
    end else begin
      // idle or simultaneous push+pop: requests cancel, nothing moves
      ptr_nxt_s = ptr_r;
    end
  end

  // Pointer and error-pulse registers; reset empties the stack immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr_r       <= TOP;
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
    end else begin
      ptr_r       <= ptr_nxt_s;
      overflow_r  <= overflow_nxt_s;
      underflow_r <= underflow_nxt_s;
    end
  end

  assign sp.out       = ptr_r;
  assign sp.empty     = (ptr_r == TOP);
  assign sp.full      = (ptr_r == LIMIT);
  assign sp.overflow  = overflow_r;
  assign sp.underflow = underflow_r;

endmodule

// File: tb/tb_stack_pointer.sv
// Directed scoreboard bench for stack_pointer: a default instance (LIMIT
// F000) and a shallow instance (LIMIT FFFD) to reach the full boundary.
module tb_stack_pointer;

  localparam logic [15:0] TOP_C  = 16'hFFFF;
  localparam logic [15:0] LIM0_C = 16'hF000;
  localparam logic [15:0] LIM1_C = 16'hFFFD;

  typedef struct {
    string       tag;
    int          d;
    logic [15:0] out;
    logic        empty;
    logic        full;
    logic        ovf;
    logic        unf;
  } exp_t;

  logic clk;
  logic reset;
  int   n_checks = 0;
  int   n_fail   = 0;

  exp_t        sb_q[$];
  logic [15:0] m_ptr [0:1];
  logic        m_ovf [0:1];
  logic        m_unf [0:1];

  stack_pointer_if #(.WIDTH(16)) if0 ();
  stack_pointer_if #(.WIDTH(16)) if1 ();

  stack_pointer dut (
    .clk   (clk),
    .reset (reset),
    .sp    (if0)
  );

  stack_pointer #(.WIDTH(16), .TOP(16'hFFFF), .LIMIT(16'hFFFD)) dut_lim (
    .clk   (clk),
    .reset (reset),
    .sp    (if1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] lim_of(input int d);
    return (d == 0) ? LIM0_C : LIM1_C;
  endfunction

  // Reference behaviour of one rising edge for instance d.
  task automatic model_step(input int d, input logic pu, input logic po);
    m_ovf[d] = 1'b0;
    m_unf[d] = 1'b0;
    if (pu && !po) begin
      if (m_ptr[d] == lim_of(d)) m_ovf[d] = 1'b1;
      else m_ptr[d] = m_ptr[d] - 16'd1;
    end else if (po && !pu) begin
      if (m_ptr[d] == TOP_C) m_unf[d] = 1'b1;
      else m_ptr[d] = m_ptr[d] + 16'd1;
    end
  endtask

  task automatic compare(input exp_t e);
    logic [15:0] o_out;
    logic        o_empty, o_full, o_ovf, o_unf;
    if (e.d == 0) begin
      o_out = if0.out; o_empty = if0.empty; o_full = if0.full;
      o_ovf = if0.overflow; o_unf = if0.underflow;
    end else begin
      o_out = if1.out; o_empty = if1.empty; o_full = if1.full;
      o_ovf = if1.overflow; o_unf = if1.underflow;
    end
    chk({e.tag, ".out"},       32'(o_out),   32'(e.out));
    chk({e.tag, ".empty"},     32'(o_empty), 32'(e.empty));
    chk({e.tag, ".full"},      32'(o_full),  32'(e.full));
    chk({e.tag, ".overflow"},  32'(o_ovf),   32'(e.ovf));
    chk({e.tag, ".underflow"}, 32'(o_unf),   32'(e.unf));
  endtask

  // Drive one cycle of push/pop on instance d, queue the expectation,
  // then compare once the edge has produced the result.
  task automatic step(input int d, input logic pu, input logic po, input string tag);
    exp_t e;
    exp_t g;
    @(negedge clk);
    if (d == 0) begin
      if0.push = pu; if0.pop = po;
    end else begin
      if1.push = pu; if1.pop = po;
    end
    model_step(d, pu, po);
    e.tag   = tag;
    e.d     = d;
    e.out   = m_ptr[d];
    e.empty = (m_ptr[d] == TOP_C);
    e.full  = (m_ptr[d] == lim_of(d));
    e.ovf   = m_ovf[d];
    e.unf   = m_unf[d];
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    g = sb_q.pop_front();
    compare(g);
  endtask

  initial begin
    reset    = 1'b0;
    if0.push = 1'b0; if0.pop = 1'b0;
    if1.push = 1'b0; if1.pop = 1'b0;
    for (int i = 0; i < 2; i++) begin
      m_ptr[i] = TOP_C; m_ovf[i] = 1'b0; m_unf[i] = 1'b0;
    end

    // reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst.out",       32'(if0.out),       32'(16'hFFFF));
    chk("rst.empty",     32'(if0.empty),     32'(1'b1));
    chk("rst.full",      32'(if0.full),      32'(1'b0));
    chk("rst.overflow",  32'(if0.overflow),  32'(1'b0));
    chk("rst.underflow", 32'(if0.underflow), 32'(1'b0));
    @(negedge clk);
    reset = 1'b1;

    // single push / pop
    step(0, 1'b1, 1'b0, "push1");
    chk("push1.plan", 32'(if0.out), 32'(16'hFFFE));
    step(0, 1'b0, 1'b1, "pop1");

    // underflow at top, then pulse clears
    step(0, 1'b0, 1'b1, "pop_at_top");
    step(0, 1'b0, 1'b0, "unf_clear");

    // held push for three edges, then one pop
    step(0, 1'b1, 1'b0, "push_a");
    step(0, 1'b1, 1'b0, "push_hold1");
    step(0, 1'b1, 1'b0, "push_hold2");
    step(0, 1'b1, 1'b0, "push_hold3");
    chk("hold3.plan", 32'(if0.out), 32'(16'hFFFB));
    step(0, 1'b0, 1'b1, "pop_after_hold");
    chk("pop_hold.plan", 32'(if0.out), 32'(16'hFFFC));
    step(0, 1'b0, 1'b1, "pop_b");
    step(0, 1'b0, 1'b1, "pop_c");

    // simultaneous push and pop cancel at FFFE
    step(0, 1'b1, 1'b1, "both1");
    step(0, 1'b1, 1'b1, "both2");
    chk("both.plan", 32'(if0.out), 32'(16'hFFFE));
    step(0, 1'b0, 1'b0, "idle0");

    // shallow instance: reach LIMIT, refused push, pulse clears
    step(1, 1'b1, 1'b0, "lim_push1");
    step(1, 1'b1, 1'b0, "lim_push2");
    step(1, 1'b1, 1'b0, "lim_push3_ovf");
    chk("lim.plan", 32'(if1.out), 32'(16'hFFFD));
    step(1, 1'b0, 1'b0, "ovf_clear");
    step(1, 1'b1, 1'b1, "both_at_full");
    step(1, 1'b0, 1'b1, "lim_pop1");
    step(1, 1'b0, 1'b1, "lim_pop2");
    step(1, 1'b1, 1'b1, "both_at_top");
    step(1, 1'b0, 1'b0, "idle1");

    // asynchronous reset between edges while push is held
    step(0, 1'b1, 1'b0, "push_pre_rst");
    #2;
    reset = 1'b0;
    #1;
    chk("async_rst.out",   32'(if0.out),   32'(16'hFFFF));
    chk("async_rst.empty", 32'(if0.empty), 32'(1'b1));
    @(posedge clk);
    #1;
    chk("rst_hold.out",      32'(if0.out),      32'(16'hFFFF));
    chk("rst_hold.overflow", 32'(if0.overflow), 32'(1'b0));
    @(negedge clk);
    reset    = 1'b1;
    if0.push = 1'b0;
    for (int i = 0; i < 2; i++) begin
      m_ptr[i] = TOP_C; m_ovf[i] = 1'b0; m_unf[i] = 1'b0;
    end
    step(0, 1'b1, 1'b0, "push_after_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
